// File: rtl/dynamics_envelope.sv
// ---------------------------------------------------------------------------
// dynamics_envelope
//
// Per-note ADSR amplitude envelope placed between the synthesizer sample
// path and the codec interface. The envelope advances on codec frame
// boundaries (frame_req), and the scaled sample is registered on every
// frame_req so the codec always sees a stable value for the whole frame.
//
// Gain is an unsigned 0..128 value where 128 is unity. The output is
// (sample_in * gain) >>> 7, so gain = 128 is an exact pass-through.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-low reset
//   enable        1 = apply envelope, 0 = unity bypass (envelope keeps running)
//   note_start    single-cycle note onset pulse (wins over note_end)
//   note_end      single-cycle note release pulse
//   frame_req     codec accept strobe, one cycle per frame
//   sample_in     signed sample from the synthesizer
//   sample_out    registered signed scaled sample to the codec
//   gain_out      effective gain (128 while bypassed)
//   state_out     envelope state: IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   busy          high whenever the envelope is not IDLE
//   note_velocity (only with DYNAMICS_ENVELOPE_VELOCITY_EN) 7-bit velocity;
//                 peak gain latched as note_velocity+1 on note_start
//
// Optional feature macro: DYNAMICS_ENVELOPE_VELOCITY_EN
//   Undefined (default): no velocity port, peak gain fixed at 128.
//
// Step parameters are expected to lie in 1..255.
// ---------------------------------------------------------------------------
module dynamics_envelope #(
  parameter int SAMPLE_WIDTH  = 16,
  parameter int STEP_FRAMES   = 48,
  parameter int ATTACK_STEP   = 4,
  parameter int DECAY_STEP    = 1,
  parameter int SUSTAIN_LEVEL = 96,
  parameter int RELEASE_STEP  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           note_start,
  input  logic                           note_end,
  input  logic                           frame_req,
`ifdef DYNAMICS_ENVELOPE_VELOCITY_EN
  input  logic [6:0]                     note_velocity,
`endif
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out,
  output logic [7:0]                     gain_out,
  output logic [2:0]                     state_out,
  output logic                           busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  // A one-frame prescaler still needs a 1-bit register to keep widths legal.
  localparam int                  PRESC_W    = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_FRAMES - 1);
  localparam logic [PRESC_W-1:0]  PRESC_ONE  = PRESC_W'(1);
  localparam logic [7:0]          ATK_STEP8  = 8'(ATTACK_STEP);
  localparam logic [7:0]          DEC_STEP8  = 8'(DECAY_STEP);
  localparam logic [7:0]          REL_STEP8  = 8'(RELEASE_STEP);
  localparam logic [7:0]          SUS_LVL8   = 8'(SUSTAIN_LEVEL);
  localparam logic [7:0]          UNITY_GAIN = 8'd128;

  env_state_t                     state, state_n;
  logic [7:0]                     gain, gain_n;
  logic [PRESC_W-1:0]             presc, presc_n;
  logic [7:0]                     peak;
  logic [7:0]                     sus_eff;
  logic signed [SAMPLE_WIDTH-1:0] sample_p1;

  // Scale a sample by a 0..128 gain: full-width signed product, then an
  // arithmetic shift (floor toward -inf). With gain <= 128 the result always
  // fits back into SAMPLE_WIDTH bits.
  function automatic logic signed [SAMPLE_WIDTH-1:0] scale_sample(
    input logic signed [SAMPLE_WIDTH-1:0] s,
    input logic [7:0]                     g
  );
    logic signed [SAMPLE_WIDTH+8:0] s_ext;
    logic signed [SAMPLE_WIDTH+8:0] g_ext;
    logic signed [SAMPLE_WIDTH+8:0] prod;
    logic signed [SAMPLE_WIDTH+8:0] shifted;
    s_ext   = {{9{s[SAMPLE_WIDTH-1]}}, s};
    g_ext   = {{(SAMPLE_WIDTH+1){1'b0}}, g};
    prod    = s_ext * g_ext;
    shifted = prod >>> 7;
    return shifted[SAMPLE_WIDTH-1:0];
  endfunction

`ifdef DYNAMICS_ENVELOPE_VELOCITY_EN
  logic [7:0] peak_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_q <= UNITY_GAIN;
    end else if (note_start) begin
      peak_q <= {1'b0, note_velocity} + 8'd1;
    end
  end

  assign peak    = peak_q;
  assign sus_eff = (SUS_LVL8 < peak_q) ? SUS_LVL8 : peak_q;
`else
  assign peak    = UNITY_GAIN;
  assign sus_eff = SUS_LVL8;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      gain  <= 8'd0;
      presc <= '0;
    end else begin
      state <= state_n;
      gain  <= gain_n;
      presc <= presc_n;
    end
  end

  // Events take priority over frame ticks; a frame_req on an event edge is
  // swallowed so the new phase always starts with a full prescaler period.
  always_comb begin
    state_n = state;
    gain_n  = gain;
    presc_n = presc;
    if (note_start) begin
      state_n = ST_ATTACK;
      presc_n = '0;
    end else if (note_end && (state == ST_ATTACK || state == ST_DECAY ||
                              state == ST_SUSTAIN)) begin
      state_n = ST_RELEASE;
      presc_n = '0;
    end else if (frame_req) begin
      if (presc == PRESC_LAST) begin
        presc_n = '0;
        case (state)
          ST_ATTACK: begin
            // A retrigger may start above the peak; that also clamps at once.
            if (gain >= peak || (peak - gain) <= ATK_STEP8) begin
              gain_n  = peak;
              state_n = ST_DECAY;
            end else begin
              gain_n = gain + ATK_STEP8;
            end
          end
          ST_DECAY: begin
            if (gain <= sus_eff || (gain - sus_eff) <= DEC_STEP8) begin
              gain_n  = sus_eff;
              state_n = ST_SUSTAIN;
            end else begin
              gain_n = gain - DEC_STEP8;
            end
          end
          ST_SUSTAIN: gain_n = gain;
          ST_RELEASE: begin
            if (gain <= REL_STEP8) begin
              gain_n  = 8'd0;
              state_n = ST_IDLE;
            end else begin
              gain_n = gain - REL_STEP8;
            end
          end
          default: gain_n = 8'd0;
        endcase
      end else begin
        presc_n = presc + PRESC_ONE;
      end
    end
  end

  // ---- stage p1: frame-aligned output register (uses pre-update gain) ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_p1 <= '0;
    end else if (frame_req) begin
      sample_p1 <= enable ? scale_sample(sample_in, gain) : sample_in;
    end
  end

  assign sample_out = sample_p1;
  assign gain_out   = enable ? gain : UNITY_GAIN;
  assign state_out  = state;
  assign busy       = (state != ST_IDLE);

endmodule
